// File: rtl/sram_ctrl_if.sv
// Memory-stage request bus of the SRAM controller: word request in, read data and ready out.
interface sram_ctrl_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output wr_en, rd_en, address, wdata, input rdata, ready);
  modport slave  (input wr_en, rd_en, address, wdata, output rdata, ready);
endinterface

// File: rtl/sram_ctrl.sv
// 32-bit word accesses split into two 16-bit async SRAM phases with programmable wait states.
// Optional read-hit shortcut for repeated reads of the same word: define SRAM_CTRL_READ_HIT_EN.
module sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_ctrl_if.slave         bus,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [31:0] BASE      = 32'(BASE_ADDR);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  state_t             state;
  logic [3:0]         wait_cnt;
  logic [SRAM_AW-2:0] word;
  logic [31:0]        wdata_q;
  logic               is_wr;
  logic [31:0]        rdata_q;

  logic               req;
  logic [31:0]        offset;
  logic [SRAM_AW-2:0] req_word;
  logic               read_hit;
  logic               unused_offset;

  assign req           = bus.rd_en | bus.wr_en;
  assign offset        = bus.address - BASE;
  assign req_word      = offset[SRAM_AW:2];
  assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

  assign bus.ready = (state == DONE) || ((state == IDLE) && !req);
  assign bus.rdata = rdata_q;

`ifdef SRAM_CTRL_READ_HIT_EN
  logic               hit_vld;
  logic [SRAM_AW-2:0] hit_word;

  assign read_hit = hit_vld && !bus.wr_en && (hit_word == req_word);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_vld  <= 1'b0;
      hit_word <= '0;
    end else if (state == IDLE && bus.wr_en) begin
      hit_vld <= 1'b0;
    end else if (state == HIGH && wait_cnt == 4'd0 && !is_wr) begin
      hit_vld  <= 1'b1;
      hit_word <= word;
    end
  end
`else
  assign read_hit = 1'b0;
`endif

  // All pad outputs are registered so nothing on the request side reaches the pins combinationally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      word        <= '0;
      wdata_q     <= '0;
      is_wr       <= 1'b0;
      rdata_q     <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_ce_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            word    <= req_word;
            wdata_q <= bus.wdata;
            is_wr   <= bus.wr_en;
            if (read_hit) begin
              state <= DONE;
            end else begin
              state       <= LOW;
              wait_cnt    <= WAIT_INIT;
              sram_addr   <= {req_word, 1'b0};
              sram_ce_n   <= 1'b0;
              sram_oe_n   <= bus.wr_en;
              sram_we_n   <= !bus.wr_en;
              sram_dq_oe  <= bus.wr_en;
              sram_dq_out <= bus.wr_en ? bus.wdata[15:0] : sram_dq_out;
            end
          end
        end
        LOW: begin
          if (wait_cnt == 4'd0) begin
            if (!is_wr) rdata_q[15:0] <= sram_dq_in;
            state     <= HIGH;
            wait_cnt  <= WAIT_INIT;
            sram_addr <= {word, 1'b1};
            sram_we_n <= !is_wr;
            if (is_wr) sram_dq_out <= wdata_q[31:16];
          end else begin
            wait_cnt  <= wait_cnt - 4'd1;
            // The final cycle of a phase keeps we_n high so data is held past the write strobe.
            sram_we_n <= !is_wr || (wait_cnt == 4'd1);
          end
        end
        HIGH: begin
          if (wait_cnt == 4'd0) begin
            if (!is_wr) rdata_q[31:16] <= sram_dq_in;
            state      <= DONE;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
          end else begin
            wait_cnt  <= wait_cnt - 4'd1;
            sram_we_n <= !is_wr || (wait_cnt == 4'd1);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
